// File: rtl/gonso_pkg.sv
// Register map shared by the gonso channel bank and its channel engine.
// Offsets, control/status bit positions, channel stride and a byte-lane helper.
package gonso_pkg;

    localparam int CH_STRIDE = 16;
    localparam int CH_SHIFT  = $clog2(CH_STRIDE);

    localparam logic [3:0] OFF_IN     = 4'h0;
    localparam logic [3:0] OFF_OUT    = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gonso_chan.sv
// One accumulate channel: OUT <= OUT + IN, result lands PIPE_LAT+1 cycles after start.
// Start while busy is dropped; clear aborts and has priority; completion beats a same-cycle done clear.
module gonso_chan #(
    parameter int DATA_W   = 20,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_wdat,
    input  logic              start,
    input  logic              clear,
    input  logic              done_clr,
    output logic [DATA_W-1:0] in_val,
    output logic [DATA_W-1:0] out_val,
    output logic              busy,
    output logic              done
);

    logic [DATA_W-1:0] op_in;
    logic [3:0]        cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_val  <= '0;
            out_val <= '0;
            op_in   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (in_we) begin
                in_val <= in_wdat;
            end
            // Later assignments below override this, so a completing op keeps done set.
            if (done_clr) begin
                done <= 1'b0;
            end
            if (clear) begin
                out_val <= '0;
                done    <= 1'b0;
                busy    <= start;
                cnt     <= 4'(PIPE_LAT);
                op_in   <= in_val;
            end else if (start && !busy) begin
                busy  <= 1'b1;
                done  <= 1'b0;
                cnt   <= 4'(PIPE_LAT);
                op_in <= in_val;
            end else if (busy) begin
                if (cnt == 4'd0) begin
                    out_val <= out_val + op_in;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/gonso_wb_regbank.sv
// Wishbone register bank of NUM_CH accumulate channels; ack one cycle after strobe, then low one cycle.
// Optional macro GONSO_IRQ_EN adds the IRQ_EN register and a registered level irq.
module gonso_wb_regbank
    import gonso_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3003_0000,
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 20,
    parameter int          PIPE_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq
);

    localparam int CIDX_W = 32 - CH_SHIFT;

    logic              acc;
    logic              wr;
    logic [31:0]       off;
    logic              above;
    logic [CIDX_W-1:0] ch_idx;
    logic [3:0]        woff;
    logic              ch_hit;
    logic [31:0]       lane_m;
    logic [DATA_W-1:0] wmask;
    logic [31:0]       rdata;

    logic [DATA_W-1:0] in_val  [NUM_CH];
    logic [DATA_W-1:0] out_val [NUM_CH];
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    // A held strobe is only taken again once the previous ack has dropped.
    assign acc    = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
    assign wr     = acc && wbs_we_i;
    assign off    = wbs_adr_i - BASE_ADDR;
    assign above  = wbs_adr_i >= BASE_ADDR;
    assign ch_idx = off[31:CH_SHIFT];
    assign woff   = {off[3:2], 2'b00};
    assign ch_hit = above && (ch_idx < CIDX_W'(NUM_CH));
    assign lane_m = lane_mask(wbs_sel_i);
    assign wmask  = lane_m[DATA_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel_ch;
        logic ctrl_wr;
        assign sel_ch  = wr && ch_hit && (ch_idx == CIDX_W'(c));
        assign ctrl_wr = sel_ch && (woff == OFF_CTRL) && wbs_sel_i[0];

        gonso_chan #(
            .DATA_W   (DATA_W),
            .PIPE_LAT (PIPE_LAT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .in_we    (sel_ch && (woff == OFF_IN)),
            .in_wdat  ((in_val[c] & ~wmask) | (wbs_dat_i[DATA_W-1:0] & wmask)),
            .start    (ctrl_wr && wbs_dat_i[CTRL_START_BIT]),
            .clear    (ctrl_wr && wbs_dat_i[CTRL_CLEAR_BIT]),
            .done_clr (sel_ch && (woff == OFF_STATUS) && wbs_sel_i[0] && wbs_dat_i[STAT_DONE_BIT]),
            .in_val   (in_val[c]),
            .out_val  (out_val[c]),
            .busy     (busy[c]),
            .done     (done[c])
        );
    end

`ifdef GONSO_IRQ_EN
    logic              irq_hit;
    logic [NUM_CH-1:0] irq_en;

    assign irq_hit = above && (ch_idx == CIDX_W'(NUM_CH)) && (off[3:2] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && irq_hit && wbs_sel_i[0]) begin
                irq_en <= wbs_dat_i[NUM_CH-1:0];
            end
            irq <= |(done & irq_en);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit && (ch_idx == CIDX_W'(c))) begin
                case (woff)
                    OFF_IN:  rdata = 32'(in_val[c]);
                    OFF_OUT: rdata = 32'(out_val[c]);
                    OFF_STATUS: begin
                        rdata[STAT_BUSY_BIT] = busy[c];
                        rdata[STAT_DONE_BIT] = done[c];
                    end
                    default: rdata = '0;
                endcase
            end
        end
`ifdef GONSO_IRQ_EN
        if (irq_hit) begin
            rdata = 32'(irq_en);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, off[1:0], lane_m, wbs_dat_i};

endmodule

// File: tb/tb_gonso_wb_regbank.sv
// Bench for gonso_wb_regbank: table vectors, timed corner sequences and a random run
// against a timestamp-based reference model of the channel bank.
module tb_gonso_wb_regbank;

    localparam logic [31:0] BASE  = 32'h3003_0000;
    localparam int          NC    = 4;
    localparam int          W     = 20;
    localparam int          P     = 3;
    localparam logic [31:0] MASKW = 32'h000F_FFFF;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        ack;
    logic        irq;

    int checks;
    int failures;
    int cyc_cnt;
    int last_k;
    logic [31:0] last_rd;

    gonso_wb_regbank #(
        .BASE_ADDR (BASE),
        .NUM_CH    (NC),
        .DATA_W    (W),
        .PIPE_LAT  (P)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_sel_i (sel),
        .wbs_dat_o (rdat),
        .wbs_ack_o (ack),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: an operation started at edge s completes at edge s+P+1.
    logic [31:0] m_in  [NC];
    logic [31:0] m_out [NC];
    logic [31:0] m_op  [NC];
    int          m_s   [NC];
    bit          m_act [NC];
    bit          m_done[NC];
    logic [31:0] m_en;

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            m_in[c] = 0; m_out[c] = 0; m_op[c] = 0; m_s[c] = 0;
            m_act[c] = 0; m_done[c] = 0;
        end
        m_en = 0;
    endfunction

    function automatic void settle(input int t);
        for (int c = 0; c < NC; c++) begin
            if (m_act[c] && t >= m_s[c] + P + 1) begin
                m_out[c]  = (m_out[c] + m_op[c]) & MASKW;
                m_act[c]  = 0;
                m_done[c] = 1;
            end
        end
    endfunction

    function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s, input int k, output logic [31:0] e);
        logic [31:0] o;
        logic [31:0] m;
        int c;
        settle(k - 1);
        e = 0;
        o = a - BASE;
        m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        m = m & MASKW;
        if (a >= BASE && o < 32'(16 * NC)) begin
            c = int'(o >> 4);
            case (o[3:2])
                2'd0: if (w) m_in[c] = (m_in[c] & ~m) | (d & m); else e = m_in[c];
                2'd1: if (!w) e = m_out[c];
                2'd2: if (w && s[0]) begin
                    if (d[1]) begin m_act[c] = 0; m_out[c] = 0; m_done[c] = 0; end
                    if (d[0] && !m_act[c]) begin
                        m_act[c] = 1; m_s[c] = k; m_op[c] = m_in[c]; m_done[c] = 0;
                    end
                end
                default: if (w) begin
                    if (s[0] && d[1]) m_done[c] = 0;
                end else begin
                    e = (m_done[c] ? 32'd2 : 32'd0) + (m_act[c] ? 32'd1 : 32'd0);
                end
            endcase
        end
`ifdef GONSO_IRQ_EN
        else if (a >= BASE && o >= 32'(16 * NC) && o < 32'(16 * NC + 4)) begin
            if (w) begin
                if (s[0]) m_en = d & 32'hF;
            end else begin
                e = m_en;
            end
        end
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Bus access; k is the edge that sampled the strobe (the ack edge).
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output int k);
        int n;
        n = 0;
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 8);
        r = rdat;
        k = cyc_cnt;
        cyc = 0; stb = 0; we = 0;
        checks++;
        if (!ack) begin
            failures++;
            $display("FAIL ack_timeout adr=%h got ack=0 expected ack=1", a);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input string name);
        logic [31:0] r, e;
        int k;
        wb(w, a, d, s, r, k);
        model_access(w, a, d, s, k, e);
        if (!w) chk(name, r, e);
        last_k  = k;
        last_rd = r;
    endtask

    function automatic logic [31:0] ra(input int c, input int offs);
        return BASE + 32'(16 * c + offs);
    endfunction

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, k0, c, op;
        logic [31:0] a;

        checks = 0; failures = 0; cyc_cnt = 0;
        tbl[0]  = '{1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0010, 32'h0};
        tbl[1]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hF,    32'h0_CC00};
        tbl[2]  = '{1'b0, 32'h3003_0FF0, 32'h0,         4'hF,    32'h0};
        tbl[3]  = '{1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0001, 32'h0};
        tbl[4]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hF,    32'h0_CC44};
        tbl[5]  = '{1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF,    32'h0};
        tbl[6]  = '{1'b0, BASE + 32'h20, 32'h0,         4'hF,    32'hF_FFFF};
        tbl[7]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hF,    32'h0};
        tbl[8]  = '{1'b1, BASE + 32'h04, 32'h0000_0123, 4'hF,    32'h0};
        tbl[9]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF,    32'h0};
        tbl[10] = '{1'b0, 32'h3002_FFFC, 32'h0,         4'hF,    32'h0};
        tbl[11] = '{1'b1, BASE + 32'h30, 32'h1234_5678, 4'b1001, 32'h0};
        tbl[12] = '{1'b0, BASE + 32'h30, 32'h0,         4'hF,    32'h0_0078};
        tbl[13] = '{1'b0, BASE + 32'h3C, 32'h0,         4'hF,    32'h0};
        tbl[14] = '{1'b0, BASE + 32'h40, 32'h0,         4'hF,    32'h0};

        // Reset with a strobe held high: ack and data must stay low.
        rst = 1; cyc = 1; stb = 1; we = 0; adr = BASE; wdat = 0; sel = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        cyc = 0; stb = 0; rst = 0;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            bus(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, "tbl_model");
            if (!tbl[i].w) chk($sformatf("tbl_%0d", i), last_rd, tbl[i].exp);
        end

        // Back-to-back accesses take two cycles; ack drops in between.
        bus(0, ra(0, 0), 0, 4'hF, "b2b_a");
        k0 = last_k;
        bus(0, ra(0, 4), 0, 4'hF, "b2b_b");
        chk("b2b_spacing", 32'(last_k - k0), 2);
        idle(1);
        chk("ack_drop", {31'd0, ack}, 0);

        // Basic add on ch0 with exact completion boundary.
        bus(1, ra(0, 0), 32'h5, 4'hF, "a_in");
        bus(1, ra(0, 8), 32'h1, 4'hF, "a_start");
        s0 = last_k;
        idle(P - 1);
        bus(0, ra(0, 12), 0, 4'hF, "a_poll_busy");
        chk("a_poll_edge", 32'(last_k - s0), P);
        chk("a_busy_before", last_rd, 32'h1);
        bus(0, ra(0, 12), 0, 4'hF, "a_poll_done");
        chk("a_done_after", last_rd, 32'h2);
        bus(0, ra(0, 4), 0, 4'hF, "a_out");
        chk("a_out0", last_rd, 32'h5);

        // Wrap on ch1.
        bus(1, ra(1, 8), 32'h2, 4'hF, "b_clr");
        bus(1, ra(1, 0), 32'hF_FFFF, 4'hF, "b_in");
        bus(1, ra(1, 8), 32'h1, 4'hF, "b_start");
        idle(P + 3);
        bus(1, ra(1, 0), 32'h3, 4'hF, "b_in2");
        bus(1, ra(1, 8), 32'h1, 4'hF, "b_start2");
        idle(P + 3);
        bus(0, ra(1, 4), 0, 4'hF, "b_out");
        chk("b_wrap", last_rd, 32'h2);

        // Second start while busy is ignored.
        bus(1, ra(2, 8), 32'h2, 4'hF, "c_clr");
        bus(1, ra(2, 0), 32'h7, 4'hF, "c_in");
        bus(1, ra(2, 8), 32'h1, 4'hF, "c_start");
        bus(1, ra(2, 8), 32'h1, 4'hF, "c_start_again");
        idle(P + 5);
        bus(0, ra(2, 4), 0, 4'hF, "c_out");
        chk("c_single_add", last_rd, 32'h7);

        // Clear+start aborts the running op and restarts from zero.
        bus(1, ra(2, 8), 32'h1, 4'hF, "d_start");
        bus(1, ra(2, 8), 32'h3, 4'hF, "d_clr_start");
        idle(P + 5);
        bus(0, ra(2, 4), 0, 4'hF, "d_out");
        chk("d_restart", last_rd, 32'h7);

        // IN written during busy applies only at the next start.
        bus(1, ra(3, 8), 32'h2, 4'hF, "e_clr");
        bus(1, ra(3, 0), 32'h4, 4'hF, "e_in");
        bus(1, ra(3, 8), 32'h1, 4'hF, "e_start");
        bus(1, ra(3, 0), 32'h9, 4'hF, "e_in_busy");
        idle(P + 3);
        bus(0, ra(3, 4), 0, 4'hF, "e_out");
        chk("e_sampled_in", last_rd, 32'h4);
        bus(1, ra(3, 8), 32'h1, 4'hF, "e_start2");
        idle(P + 3);
        bus(0, ra(3, 4), 0, 4'hF, "e_out2");
        chk("e_next_in", last_rd, 32'hD);

        // Done W1C on the completion edge: done stays set; plain W1C clears.
        bus(1, ra(0, 8), 32'h1, 4'hF, "f_start");
        s0 = last_k;
        idle(P);
        bus(1, ra(0, 12), 32'h2, 4'hF, "f_w1c");
        chk("f_w1c_edge", 32'(last_k - s0), P + 1);
        bus(0, ra(0, 12), 0, 4'hF, "f_status");
        chk("f_done_wins", last_rd, 32'h2);
        bus(1, ra(0, 12), 32'h2, 4'hF, "f_w1c2");
        bus(0, ra(0, 12), 0, 4'hF, "f_status2");
        chk("f_done_clr", last_rd, 32'h0);

        // Reset in the middle of an operation.
        bus(1, ra(0, 8), 32'h1, 4'hF, "g_start");
        idle(1);
        rst = 1;
        idle(1);
        rst = 0;
        model_reset();
        idle(P + 5);
        bus(0, ra(0, 12), 0, 4'hF, "g_status");
        chk("g_status0", last_rd, 32'h0);
        bus(0, ra(0, 4), 0, 4'hF, "g_out");
        chk("g_out0", last_rd, 32'h0);
        bus(0, ra(0, 0), 0, 4'hF, "g_in");
        chk("g_in0", last_rd, 32'h0);
        chk("g_irq", {31'd0, irq}, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            c  = $urandom_range(NC - 1, 0);
            op = $urandom_range(9, 0);
            a  = ra(c, 0);
            case (op)
                0, 1:    bus(1, a, $urandom, 4'($urandom_range(15, 0)), "rand_in");
                2, 3, 4: bus(0, a + 32'(4 * $urandom_range(3, 0)), 0, 4'hF, "rand_rd");
                5:       bus(1, a + 32'h8, 32'h1, 4'hF, "rand_start");
                6:       bus(1, a + 32'h8, 32'($urandom_range(3, 2)), 4'hF, "rand_clr");
                7:       bus(1, a + 32'hC, 32'h2, 4'hF, "rand_w1c");
                8:       bus(0, BASE + 32'(64 + 4 * $urandom_range(7, 0)), 0, 4'hF, "rand_unmapped");
                default: bus(1, a + 32'h4, $urandom, 4'hF, "rand_ro");
            endcase
            idle($urandom_range(4, 0));
        end
        idle(P + 10);
        for (int i = 0; i < NC; i++) begin
            bus(0, ra(i, 4), 0, 4'hF, "final_out");
            bus(0, ra(i, 12), 0, 4'hF, "final_status");
            bus(1, ra(i, 12), 32'h2, 4'hF, "final_w1c");
        end

`ifdef GONSO_IRQ_EN
        bus(1, BASE + 32'h40, 32'h4, 4'hF, "irq_en_w");
        bus(0, BASE + 32'h40, 0, 4'hF, "irq_en_r");
        chk("irq_en_val", last_rd, 32'h4);
        bus(1, ra(2, 8), 32'h2, 4'hF, "irq_clr2");
        bus(1, ra(2, 0), 32'h1, 4'hF, "irq_in2");
        bus(1, ra(2, 8), 32'h1, 4'hF, "irq_start2");
        idle(P + 4);
        chk("irq_set", {31'd0, irq}, 1);
        bus(1, ra(2, 12), 32'h2, 4'hF, "irq_w1c2");
        idle(1);
        chk("irq_w1c", {31'd0, irq}, 0);
        bus(1, ra(0, 0), 32'h1, 4'hF, "irq_in0");
        bus(1, ra(0, 8), 32'h1, 4'hF, "irq_start0");
        idle(P + 4);
        chk("irq_masked", {31'd0, irq}, 0);
        bus(0, ra(0, 12), 0, 4'hF, "irq_status0");
        chk("irq_status0_done", last_rd, 32'h2);
`else
        bus(1, BASE + 32'h40, 32'hF, 4'hF, "irq_en_unmapped_w");
        bus(0, BASE + 32'h40, 0, 4'hF, "irq_en_unmapped_r");
        chk("irq_en_unmapped", last_rd, 32'h0);
        bus(1, ra(2, 0), 32'h1, 4'hF, "noirq_in2");
        bus(1, ra(2, 8), 32'h1, 4'hF, "noirq_start2");
        idle(P + 4);
        chk("irq_tied", {31'd0, irq}, 0);
        bus(0, ra(2, 12), 0, 4'hF, "noirq_status2");
        chk("noirq_status2_done", last_rd, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
